instruction_fetch_stage: RTL and testbench
==========================================

// Module: instruction_fetch_stage
// PURPOSE
//  IF stage of the MIPS-32 pipeline: owns the program counter and the IF/ID pipeline register.
//  - Drives the word index PC into INSTRUCTIONMEMORY.ReadAddress and takes back its combinational Instruction.
//  - Registers {Instruction, PC+1, valid} for the decode stage.
//  - Handles decode-side stall and branch redirect/flush.
// PARAMETERS
//  IMEM_DEPTH  65     number of instruction words; valid PC range 0..IMEM_DEPTH-1
//  RESET_PC    0      PC value loaded on reset
//  NOP_WORD    32'h0  word injected into IF/ID on flush or reset (sll $0,$0,0)
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   synchronous, active-high reset
//  Stall            in   1   hold PC and IF/ID (load-use hazard from ID)
//  BranchTaken      in   1   redirect request, resolved in ID
//  BranchTarget     in   32  word index of redirect target
//  ReadAddress      out  32  current PC, wired to instruction memory
//  Instruction      in   32  instruction memory read data for ReadAddress, same cycle
//  IfId_Instruction out  32  registered instruction for ID
//  IfId_PCPlus1     out  32  registered PC+1 of that instruction
//  IfId_Valid       out  1   1 = IfId_Instruction is a real fetch; 0 = bubble
//  FetchCount       out  32  number of instructions accepted into IF/ID
//  AddrError        out  1   sticky: a redirect targeted an index >= IMEM_DEPTH
// BEHAVIOUR
//  Reset values (reset=1 at a rising edge)
//   - PC=RESET_PC, IfId_Instruction=NOP_WORD, IfId_PCPlus1=0, IfId_Valid=0, FetchCount=0, AddrError=0.
//   - Reset mid-operation discards everything in flight; reset has top priority.
//  Datapath
//   - ReadAddress = PC, purely combinational from the PC register.
//   - The memory read is combinational, so an instruction fetched at PC in cycle n appears on IfId_* in cycle n+1.
//  Next-PC priority, evaluated each edge (highest first)
//   1 reset
//   2 BranchTaken: PC=BranchTarget if BranchTarget < IMEM_DEPTH, else PC=0 and AddrError<=1.
//     Also: IfId_Instruction=NOP_WORD, IfId_Valid=0, IfId_PCPlus1=0. Redirect overrides Stall.
//   3 Stall: PC and all IfId_* hold their values; FetchCount holds.
//   4 normal: IF/ID <= {Instruction, PC+1, 1}; FetchCount += 1 (wraps at 2^32).
//     PC <= PC+1, or 0 when PC == IMEM_DEPTH-1 (wrap; IfId_PCPlus1 still reports PC+1 unwrapped).
//  Boundaries
//   - BranchTaken and Stall in the same cycle: redirect wins and no fetch is counted.
//   - Back-to-back BranchTaken: each edge reloads PC; IF/ID stays a bubble.
//   - AddrError clears only on reset.
//   - PC never leaves 0..IMEM_DEPTH-1, so instruction memory is never indexed out of range.
// STRUCTURE
//  Shared package mips_pkg
//   - WORD_W=32, NOP_WORD constant.
//   - typedef if_id_t {instr[31:0], pc_plus1[31:0], valid}; ID imports the same type.
//  Sub-module fetch_pc_reg
//   - PC register plus next-PC mux (reset/redirect/stall/increment/wrap/range check) and AddrError.
//  This module adds the IF/ID register and FetchCount around it.
// TESTING (bench instantiates INSTRUCTIONMEMORY as the memory model)
//  T1 reset 3 cycles, release, 5 free cycles
//     -> ReadAddress 0,1,2,3,4
//     -> IfId_Instruction at cycle 1 = 32'h02324020, IfId_PCPlus1=1, Valid=1; FetchCount=5.
//  T2 Stall high 2 cycles while PC=4
//     -> ReadAddress stays 4, IfId_* unchanged, FetchCount unchanged
//     -> after release, IF/ID gets 32'h02744820 with PCPlus1=5.
//  T3 BranchTaken=1, BranchTarget=64, with Stall=1 in the same cycle
//     -> next ReadAddress=64, IfId_Valid=0, IfId_Instruction=0
//     -> next cycle IF/ID=32'h02324020, PCPlus1=65.
//  T4 free-run from PC=63 -> ReadAddress 63,64,0,1 (wrap).
//  T5 BranchTaken with BranchTarget=100 -> ReadAddress=0, AddrError=1 and stays 1 until reset.
//  T6 reset asserted while PC=10 and IfId_Valid=1
//     -> next edge: PC=0, IfId_Valid=0, FetchCount=0, AddrError=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: word width, bubble instruction and the IF/ID record shared by fetch and decode.
package mips_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;
    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pc_plus1;
        logic              valid;
    } if_id_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with redirect/stall/increment selection and sticky redirect range error.
module fetch_pc_reg
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH = 65,
    parameter int RESET_PC   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic [WORD_W-1:0] pc,
    output logic              addr_error
);
    localparam logic [WORD_W-1:0] LAST_PC = WORD_W'(IMEM_DEPTH - 1);
    logic [WORD_W-1:0] pc_d, pc_q;
    logic              err_d, err_q;
    logic              in_range;
    always_comb begin
        in_range = branch_target <= LAST_PC;
        pc_d     = branch_taken ? (in_range ? branch_target : '0)
                 : stall        ? pc_q
                 : (pc_q == LAST_PC ? '0 : pc_q + 32'd1);
        err_d    = err_q | (branch_taken & ~in_range);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= WORD_W'(RESET_PC);
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end
    assign pc         = pc_q;
    assign addr_error = err_q;
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: MIPS-32 IF stage; PC drives instruction memory, result is registered into IF/ID.
module instruction_fetch_stage
    import mips_pkg::*;
#(
    parameter int                IMEM_DEPTH = 65,
    parameter int                RESET_PC   = 0,
    parameter logic [WORD_W-1:0] NOP        = NOP_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic              BranchTaken,
    input  logic [WORD_W-1:0] BranchTarget,
    output logic [WORD_W-1:0] ReadAddress,
    input  logic [WORD_W-1:0] Instruction,
    output logic [WORD_W-1:0] IfId_Instruction,
    output logic [WORD_W-1:0] IfId_PCPlus1,
    output logic              IfId_Valid,
    output logic [WORD_W-1:0] FetchCount,
    output logic              AddrError
);
    if_id_t            if_id_d, if_id_q;
    logic [WORD_W-1:0] count_d, count_q;
    fetch_pc_reg #(.IMEM_DEPTH(IMEM_DEPTH), .RESET_PC(RESET_PC)) u_pc (
        .clk          (clk),
        .reset        (reset),
        .stall        (Stall),
        .branch_taken (BranchTaken),
        .branch_target(BranchTarget),
        .pc           (ReadAddress),
        .addr_error   (AddrError)
    );
    // PCPlus1 is the unwrapped successor so ID sees the true sequential address
    always_comb begin
        if_id_d = BranchTaken ? '{instr: NOP, pc_plus1: '0, valid: 1'b0}
                : Stall       ? if_id_q
                : '{instr: Instruction, pc_plus1: ReadAddress + 32'd1, valid: 1'b1};
        count_d = (BranchTaken | Stall) ? count_q : count_q + 32'd1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q <= '{instr: NOP, pc_plus1: '0, valid: 1'b0};
            count_q <= '0;
        end else begin
            if_id_q <= if_id_d;
            count_q <= count_d;
        end
    end
    assign IfId_Instruction = if_id_q.instr;
    assign IfId_PCPlus1     = if_id_q.pc_plus1;
    assign IfId_Valid       = if_id_q.valid;
    assign FetchCount       = count_q;
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed scenarios plus random stall/redirect/reset traffic against a behavioural model.
module tb_instruction_fetch_stage;
    localparam int DEPTH = 65;
    logic        clk = 1'b0;
    logic        reset = 1'b1, Stall = 1'b0, BranchTaken = 1'b0;
    logic [31:0] BranchTarget = '0;
    logic [31:0] ReadAddress, Instruction, IfId_Instruction, IfId_PCPlus1, FetchCount;
    logic        IfId_Valid, AddrError;
    logic [31:0] mem [0:DEPTH-1];
    int          n_tests = 0, n_fail = 0;
    logic [31:0] m_pc, m_instr, m_pcp1, m_count;
    logic        m_valid, m_err;
    bit          model_ok = 0;

    always #5 clk = ~clk;
    assign Instruction = (ReadAddress < DEPTH) ? mem[ReadAddress] : 32'hDEAD_BEEF;

    instruction_fetch_stage dut (
        .clk(clk), .reset(reset), .Stall(Stall), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .ReadAddress(ReadAddress), .Instruction(Instruction),
        .IfId_Instruction(IfId_Instruction), .IfId_PCPlus1(IfId_PCPlus1),
        .IfId_Valid(IfId_Valid), .FetchCount(FetchCount), .AddrError(AddrError)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Reference: architectural behaviour, one update per rising edge
    always @(posedge clk) begin
        if (reset) begin
            m_pc = 0; m_instr = 0; m_pcp1 = 0; m_valid = 0; m_count = 0; m_err = 0;
        end else if (BranchTaken) begin
            if (BranchTarget < DEPTH) m_pc = BranchTarget;
            else begin m_pc = 0; m_err = 1; end
            m_instr = 0; m_pcp1 = 0; m_valid = 0;
        end else if (!Stall) begin
            m_instr = mem[m_pc]; m_pcp1 = m_pc + 1; m_valid = 1; m_count = m_count + 1;
            m_pc = (m_pc + 1) % DEPTH;
        end
        model_ok = 1;
    end

    always @(negedge clk) if (model_ok) begin
        chk("m_pc", ReadAddress, m_pc);
        chk("m_instr", IfId_Instruction, m_instr);
        chk("m_pcp1", IfId_PCPlus1, m_pcp1);
        chk("m_valid", {31'd0, IfId_Valid}, {31'd0, m_valid});
        chk("m_count", FetchCount, m_count);
        chk("m_err", {31'd0, AddrError}, {31'd0, m_err});
    end

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        reset = r; Stall = s; BranchTaken = b; BranchTarget = t;
        @(posedge clk); #2;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'h0232_4020; mem[4] = 32'h0274_4820; mem[64] = 32'h0232_4020;
        // T1
        repeat (3) step(1, 0, 0, 0);
        chk("t1_rst_pc", ReadAddress, 0);
        chk("t1_rst_valid", {31'd0, IfId_Valid}, 0);
        chk("t1_rst_cnt", FetchCount, 0);
        for (int i = 0; i < 5; i++) begin
            chk("t1_addr", ReadAddress, i);
            step(0, 0, 0, 0);
            if (i == 0) begin
                chk("t1_instr", IfId_Instruction, 32'h0232_4020);
                chk("t1_pcp1", IfId_PCPlus1, 1);
                chk("t1_valid", {31'd0, IfId_Valid}, 1);
            end
        end
        chk("t1_cnt", FetchCount, 5);
        // T2
        step(1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0);
        repeat (2) begin
            step(0, 1, 0, 0);
            chk("t2_addr", ReadAddress, 4);
            chk("t2_pcp1", IfId_PCPlus1, 4);
            chk("t2_cnt", FetchCount, 4);
        end
        step(0, 0, 0, 0);
        chk("t2_instr", IfId_Instruction, 32'h0274_4820);
        chk("t2_pcp1_rel", IfId_PCPlus1, 5);
        // T3
        step(0, 1, 1, 64);
        chk("t3_addr", ReadAddress, 64);
        chk("t3_valid", {31'd0, IfId_Valid}, 0);
        chk("t3_instr", IfId_Instruction, 0);
        chk("t3_cnt", FetchCount, 5);
        step(0, 0, 0, 0);
        chk("t3_instr2", IfId_Instruction, 32'h0232_4020);
        chk("t3_pcp1", IfId_PCPlus1, 65);
        // T4
        step(0, 0, 1, 63);
        chk("t4_a63", ReadAddress, 63);
        step(0, 0, 0, 0); chk("t4_a64", ReadAddress, 64);
        step(0, 0, 0, 0); chk("t4_a0", ReadAddress, 0);
        step(0, 0, 0, 0); chk("t4_a1", ReadAddress, 1);
        step(0, 0, 1, 20); step(0, 0, 1, 30);
        chk("b2b_addr", ReadAddress, 30);
        chk("b2b_valid", {31'd0, IfId_Valid}, 0);
        // T5
        step(0, 0, 1, 100);
        chk("t5_addr", ReadAddress, 0);
        chk("t5_err", {31'd0, AddrError}, 1);
        step(0, 0, 1, 5); step(0, 0, 0, 0);
        chk("t5_sticky", {31'd0, AddrError}, 1);
        // T6
        step(0, 0, 1, 9); step(0, 0, 0, 0);
        chk("t6_pre_pc", ReadAddress, 10);
        step(1, 0, 0, 0);
        chk("t6_pc", ReadAddress, 0);
        chk("t6_valid", {31'd0, IfId_Valid}, 0);
        chk("t6_cnt", FetchCount, 0);
        chk("t6_err", {31'd0, AddrError}, 0);
        // Random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 80));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
